alu_cmd_sequencer: RTL and testbench

- Command-level controller for the register-output ALU in the system clock domain.
- Parses byte frames from the RX path (operands A, B and function code) and drives the ALU operand/function/enable lines plus the ALU clock-gate enable.
- Captures the 2*DATA_WIDTH result after the ALU's fixed one-cycle latency and serialises it, LSB byte first, to the TX FIFO using a valid/ready handshake.

---
 rtl/alu_ctrl_pkg.sv | 22 ++
 rtl/alu_cmd_sequencer.sv | 116 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Holds the FSM state encoding, default command bytes and byte width.
// No logic; imported by the sequencer.
package alu_ctrl_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] CMD_ALU_OP_DEF  = 8'hCC;
    localparam logic [BYTE_W-1:0] CMD_ALU_NOP_DEF = 8'hDD;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_A   = 3'd1,
        ST_GET_B   = 3'd2,
        ST_GET_FUN = 3'd3,
        ST_EXEC    = 3'd4,
        ST_CAPTURE = 3'd5,
        ST_SEND_LO = 3'd6,
        ST_SEND_HI = 3'd7
    } state_t;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Parses RX command frames, drives the register-output ALU and serialises its result to TX.
// Latency: FUN byte at edge N -> ALU_EN during N..N+1 -> first TX_VALID from edge N+2.
// Backpressure: SEND_LO/SEND_HI hold TX_DATA/TX_VALID until TX_READY; RX bytes then are dropped.
module alu_cmd_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH  = BYTE_W,
    parameter int                    FUN_WIDTH   = 4,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = CMD_ALU_OP_DEF,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = CMD_ALU_NOP_DEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_DATA,
    input  logic                    RX_VALID,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    output logic [DATA_WIDTH-1:0]   ALU_A,
    output logic [DATA_WIDTH-1:0]   ALU_B,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    ALU_EN,
    output logic                    ALU_CLK_EN,
    output logic [DATA_WIDTH-1:0]   TX_DATA,
    output logic                    TX_VALID,
    input  logic                    TX_READY,
    output logic                    BUSY,
    output logic                    DROP_ERR
);

    state_t                  state;
    logic [2*DATA_WIDTH-1:0] result;

    // Frame FSM; every output is registered and set on the transition into the state that owns it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            ALU_A      <= '0;
            ALU_B      <= '0;
            ALU_FUN    <= '0;
            ALU_EN     <= 1'b0;
            ALU_CLK_EN <= 1'b0;
            result     <= '0;
            TX_DATA    <= '0;
            TX_VALID   <= 1'b0;
            BUSY       <= 1'b0;
            DROP_ERR   <= 1'b0;
        end else begin
            DROP_ERR <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Unknown bytes between frames are line noise, not errors.
                    if (RX_VALID && RX_DATA == CMD_ALU_OP) begin
                        state <= ST_GET_A;
                        BUSY  <= 1'b1;
                    end else if (RX_VALID && RX_DATA == CMD_ALU_NOP) begin
                        state <= ST_GET_FUN;
                        BUSY  <= 1'b1;
                    end
                end
                ST_GET_A: begin
                    if (RX_VALID) begin
                        ALU_A <= RX_DATA;
                        state <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (RX_VALID) begin
                        ALU_B <= RX_DATA;
                        state <= ST_GET_FUN;
                    end
                end
                ST_GET_FUN: begin
                    if (RX_VALID) begin
                        ALU_FUN    <= RX_DATA[FUN_WIDTH-1:0];
                        state      <= ST_EXEC;
                        ALU_EN     <= 1'b1;
                        ALU_CLK_EN <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    // Keep the ALU clock running one more cycle so its output register loads.
                    state    <= ST_CAPTURE;
                    ALU_EN   <= 1'b0;
                    DROP_ERR <= RX_VALID;
                end
                ST_CAPTURE: begin
                    // The ALU's own valid flag is ignored: every frame returns a result.
                    result     <= ALU_OUT;
                    ALU_CLK_EN <= 1'b0;
                    TX_DATA    <= ALU_OUT[DATA_WIDTH-1:0];
                    TX_VALID   <= 1'b1;
                    state      <= ST_SEND_LO;
                    DROP_ERR   <= RX_VALID;
                end
                ST_SEND_LO: begin
                    DROP_ERR <= RX_VALID;
                    if (TX_READY) begin
                        TX_DATA <= result[2*DATA_WIDTH-1:DATA_WIDTH];
                        state   <= ST_SEND_HI;
                    end
                end
                ST_SEND_HI: begin
                    DROP_ERR <= RX_VALID;
                    if (TX_READY) begin
                        TX_VALID <= 1'b0;
                        BUSY     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural register-output ALU.
// Directed table, hand-written corner sequences and randomized frames vs a reference model.
// Every bounded wait that expires is reported as a failed check.
module tb_alu_cmd_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_DATA = '0;
    logic        RX_VALID = 1'b0;
    logic [15:0] ALU_OUT;
    logic [7:0]  ALU_A, ALU_B, TX_DATA;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN, ALU_CLK_EN, TX_VALID, BUSY, DROP_ERR;
    logic        TX_READY = 1'b1;

    int passed = 0;
    int total  = 0;

    logic [7:0] tx_q[$];
    int en_cnt = 0, clk_en_cnt = 0, drop_cnt = 0;
    logic [7:0] model_a = '0, model_b = '0;
    bit rnd_ready = 0;

    alu_cmd_sequencer dut (
        .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .ALU_OUT(ALU_OUT), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
        .ALU_EN(ALU_EN), .ALU_CLK_EN(ALU_CLK_EN), .TX_DATA(TX_DATA),
        .TX_VALID(TX_VALID), .TX_READY(TX_READY), .BUSY(BUSY), .DROP_ERR(DROP_ERR)
    );

    always #5 CLK = ~CLK;

    // Reference ALU behaviour, plain arithmetic per function code.
    function automatic logic [15:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        logic [15:0] wa, wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (f)
            4'h0: return wa + wb;
            4'h1: return wa - wb;
            4'h2: return wa * wb;
            4'h3: return (b != 0) ? wa / wb : 16'h0;
            4'h4: return wa & wb;
            4'h5: return wa | wb;
            4'h6: return {8'h00, ~(a & b)};
            4'h7: return {8'h00, ~(a | b)};
            4'h8: return wa ^ wb;
            4'h9: return {8'h00, ~(a ^ b)};
            4'hA: return (a == b) ? 16'h1 : 16'h0;
            4'hB: return (a > b) ? 16'h1 : 16'h0;
            4'hC: return (a < b) ? 16'h1 : 16'h0;
            4'hD: return wa >> 1;
            4'hE: return wa << 1;
            default: return 16'h0;
        endcase
    endfunction

    // ALU stand-in: result registered one cycle after ALU_EN, otherwise a junk pattern.
    always @(posedge CLK or negedge RST) begin
        if (!RST) ALU_OUT <= '0;
        else      ALU_OUT <= ALU_EN ? ref_alu(ALU_A, ALU_B, ALU_FUN) : 16'hA5C3;
    end

    // Record every completed TX handshake.
    always @(posedge CLK) begin
        if (RST && TX_VALID && TX_READY) tx_q.push_back(TX_DATA);
    end

    // Count enable and drop cycles between edges.
    always @(negedge CLK) begin
        if (ALU_EN)     en_cnt++;
        if (ALU_CLK_EN) clk_en_cnt++;
        if (DROP_ERR)   drop_cnt++;
    end

    // Random TX backpressure when enabled.
    always @(negedge CLK) begin
        if (rnd_ready) TX_READY = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        @(negedge CLK);
        RX_VALID = 1'b0;
    endtask

    task automatic wait_tx(input int n, input string name);
        int k;
        k = 0;
        while (tx_q.size() < n && k < 300) begin
            @(negedge CLK);
            k++;
        end
        if (tx_q.size() < n) check({name, "_timeout"}, tx_q.size(), n);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!TX_VALID && k < 30) begin
            @(negedge CLK);
            k++;
        end
        if (!TX_VALID) check({name, "_valid_timeout"}, TX_VALID, 1);
    endtask

    task automatic send_frame(input bit is_op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] fun, input bit gaps);
        if (is_op) begin
            send_byte(8'hCC);
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge CLK);
            send_byte(a);
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge CLK);
            send_byte(b);
            model_a = a;
            model_b = b;
        end else begin
            send_byte(8'hDD);
        end
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge CLK);
        send_byte(fun);
    endtask

    task automatic run_frame(input string name, input bit is_op, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] fun, input logic [7:0] exp_lo, input logic [7:0] exp_hi, input bit gaps);
        tx_q.delete();
        en_cnt = 0;
        clk_en_cnt = 0;
        send_frame(is_op, a, b, fun, gaps);
        wait_tx(2, name);
        repeat (2) @(negedge CLK);
        if (tx_q.size() >= 2) begin
            check({name, "_lo"}, tx_q[0], exp_lo);
            check({name, "_hi"}, tx_q[1], exp_hi);
        end
        check({name, "_nbytes"}, tx_q.size(), 2);
        check({name, "_en_cycles"}, en_cnt, 1);
        check({name, "_clk_en_cycles"}, clk_en_cnt, 2);
        check({name, "_busy_after"}, BUSY, 0);
        check({name, "_clk_en_idle"}, ALU_CLK_EN, 0);
        check({name, "_alu_a"}, ALU_A, model_a);
        check({name, "_alu_b"}, ALU_B, model_b);
    endtask

    typedef struct {
        bit         is_op;
        logic [7:0] a, b, fun, exp_lo, exp_hi;
    } vec_t;

    initial begin
        vec_t vecs[5];
        logic [7:0] ra, rb, rf, junk;
        logic [15:0] rexp;
        bit rop;
        int drops0;

        vecs[0] = '{1'b1, 8'h05, 8'h03, 8'h00, 8'h08, 8'h00};  // add
        vecs[1] = '{1'b1, 8'hFF, 8'hFF, 8'h02, 8'h01, 8'hFE};  // mul
        vecs[2] = '{1'b0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};  // NOP sub on FF,FF
        vecs[3] = '{1'b1, 8'h07, 8'h09, 8'h0A, 8'h00, 8'h00};  // equal, false
        vecs[4] = '{1'b1, 8'h34, 8'h16, 8'hF4, 8'h14, 8'h00};  // and, upper fun bits set

        // Reset state
        #12;
        check("rst_tx_valid", TX_VALID, 0);
        check("rst_busy", BUSY, 0);
        check("rst_alu_en", ALU_EN, 0);
        check("rst_clk_en", ALU_CLK_EN, 0);
        check("rst_drop", DROP_ERR, 0);
        check("rst_operands", {ALU_A, ALU_B, 4'(ALU_FUN), TX_DATA}, 0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // Directed table
        for (int i = 0; i < 5; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].is_op, vecs[i].a, vecs[i].b, vecs[i].fun,
                      vecs[i].exp_lo, vecs[i].exp_hi, 1'b0);

        // Latency: FUN accepted at edge N
        tx_q.delete();
        send_frame(1'b1, 8'h02, 8'h03, 8'h00, 1'b0);
        check("lat_en_n", ALU_EN, 1);
        check("lat_clk_en_n", ALU_CLK_EN, 1);
        check("lat_txv_n", TX_VALID, 0);
        @(negedge CLK);
        check("lat_en_n1", ALU_EN, 0);
        check("lat_clk_en_n1", ALU_CLK_EN, 1);
        check("lat_txv_n1", TX_VALID, 0);
        @(negedge CLK);
        check("lat_txv_n2", TX_VALID, 1);
        check("lat_txd_n2", TX_DATA, 8'h05);
        check("lat_clk_en_n2", ALU_CLK_EN, 0);
        wait_tx(2, "lat");
        @(negedge CLK);

        // Backpressure in SEND_LO
        TX_READY = 1'b0;
        tx_q.delete();
        send_frame(1'b1, 8'h20, 8'h30, 8'h00, 1'b0);
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_hold", TX_VALID, 1);
            check("bp_data_hold", TX_DATA, 8'h50);
            @(negedge CLK);
        end
        check("bp_no_xfer", tx_q.size(), 0);
        TX_READY = 1'b1;
        wait_tx(2, "bp");
        if (tx_q.size() >= 2) begin
            check("bp_lo", tx_q[0], 8'h50);
            check("bp_hi", tx_q[1], 8'h00);
        end

        // Drop during SEND_HI
        repeat (2) @(negedge CLK);
        TX_READY = 1'b0;
        tx_q.delete();
        drops0 = drop_cnt;
        send_frame(1'b1, 8'h12, 8'h34, 8'h02, 1'b0);
        wait_valid("drop");
        TX_READY = 1'b1;
        @(negedge CLK);
        TX_READY = 1'b0;
        send_byte(8'h55);
        check("drop_pulse", DROP_ERR, 1);
        @(negedge CLK);
        check("drop_pulse_end", DROP_ERR, 0);
        check("drop_count", drop_cnt - drops0, 1);
        check("drop_hi_stable", TX_DATA, 8'h03);
        check("drop_operands", {ALU_A, ALU_B}, 16'h1234);
        TX_READY = 1'b1;
        wait_tx(2, "drop");
        if (tx_q.size() >= 2) begin
            check("drop_lo", tx_q[0], 8'hA8);
            check("drop_hi", tx_q[1], 8'h03);
        end

        // Non-command byte in IDLE
        repeat (2) @(negedge CLK);
        drops0 = drop_cnt;
        send_byte(8'hAB);
        check("idle_ab_busy", BUSY, 0);
        @(negedge CLK);
        check("idle_ab_drop", drop_cnt - drops0, 0);
        check("idle_ab_busy2", BUSY, 0);

        // Randomized frames with noise bytes, gaps and TX stalls
        drops0 = drop_cnt;
        rnd_ready = 1;
        for (int i = 0; i < 30; i++) begin
            junk = 8'($urandom);
            if (junk == 8'hCC || junk == 8'hDD) junk = 8'h00;
            send_byte(junk);
            rop = (i == 0) || ($urandom_range(0, 3) != 0);
            ra = 8'($urandom);
            rb = 8'($urandom);
            rf = 8'($urandom);
            rexp = ref_alu(rop ? ra : model_a, rop ? rb : model_b, rf[3:0]);
            run_frame($sformatf("rnd%0d", i), rop, ra, rb, rf, rexp[7:0], rexp[15:8], 1'b1);
        end
        rnd_ready = 0;
        @(negedge CLK);
        TX_READY = 1'b1;
        check("rnd_no_drops", drop_cnt - drops0, 0);

        // Reset during SEND_HI
        repeat (2) @(negedge CLK);
        TX_READY = 1'b0;
        send_frame(1'b1, 8'h40, 8'h41, 8'h00, 1'b0);
        wait_valid("rst");
        TX_READY = 1'b1;
        @(negedge CLK);
        TX_READY = 1'b0;
        check("rst_mid_in_send_hi", TX_DATA, 8'h00);
        RST = 1'b0;
        #1;
        check("rst_mid_tx_valid", TX_VALID, 0);
        check("rst_mid_operands", {ALU_A, ALU_B}, 0);
        check("rst_mid_busy", BUSY, 0);
        @(negedge CLK);
        RST = 1'b1;
        TX_READY = 1'b1;
        tx_q.delete();
        model_a = '0;
        model_b = '0;
        repeat (5) @(negedge CLK);
        check("rst_no_partial", tx_q.size(), 0);
        run_frame("post_rst", 1'b1, 8'h02, 8'h02, 8'h00, 8'h04, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
